// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access stage.
//   - data/address widths, funct3 load/store encodings, wb_sel encodings
//   - FSM state enum
//   - eff_off(): forces offset bits below the access size to zero
package mem_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = 4;
  localparam int unsigned RDW  = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Halfword keeps only off[1]; word always uses offset 0.
  function automatic logic [1:0] eff_off(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   eff_off = off & 2'b10;
      2'b10:   eff_off = 2'b00;
      default: eff_off = off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/grant/response bus.
//   master (pipeline stage): drives dmem_req/we/addr/be/wdata, receives gnt/rvalid/rdata
//   slave  (memory)        : the reverse
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [BEW-1:0]  dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_align.sv
// mem_align: combinational store lane steering and load extraction/extension.
//   i_funct3 : access size / signedness
//   i_off    : byte offset within the word (already size-masked)
//   i_rs2    : store data          i_rdata : raw load word
//   o_be     : store byte enables  o_wdata : replicated store data
//   o_ldata  : aligned, extended load result
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_rdata,
  output logic [BEW-1:0]  o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_ldata
);

  logic [XLEN-1:0] w_shift;

  // Store side: byte enables shifted to the lane, data replicated across lanes.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_rs2;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = BEW'(4'b0001 << i_off);
        o_wdata = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        o_be    = BEW'(4'b0011 << i_off);
        o_wdata = {2{i_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then size and extend.
  assign w_shift = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_ldata = w_shift;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_BU:   o_ldata = {24'd0, w_shift[7:0]};
      F3_HU:   o_ldata = {16'd0, w_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage.
//   clk, rst            : clock, synchronous active-high reset
//   EX_MEM_*            : EX/MEM pipeline register (held stable while MEM_stall=1)
//   dmem (master)       : data-memory request/grant/response bus; request side is combinational
//   MEM_stall           : combinational hold for upstream stages
//   MEM_WB_*            : registered MEM/WB pipeline register
// Optional feature: define MEM_MISALIGN_CHK_EN to trap misaligned half/word accesses
// locally (no bus request, MEM_WB_misalign=1); otherwise low offset bits are masked.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_MEM_vld,
  input  logic [XLEN-1:0] EX_MEM_alu_res,
  input  logic [XLEN-1:0] EX_MEM_rs2_data,
  input  logic [2:0]      EX_MEM_funct3,
  input  logic            EX_MEM_mem_read,
  input  logic            EX_MEM_mem_write,
  input  logic [1:0]      EX_MEM_wb_sel,
  input  logic [RDW-1:0]  EX_MEM_rd,
  mem_stage_if.master     dmem,
  output logic            MEM_stall,
  output logic [XLEN-1:0] MEM_WB_alu_res,
  output logic [XLEN-1:0] MEM_WB_mem_dout,
  output logic [1:0]      MEM_WB_wb_sel,
  output logic            MEM_WB_vld,
  output logic [RDW-1:0]  MEM_WB_rd,
  output logic            MEM_WB_misalign
);

  state_t          r_state, w_next;
  logic            w_mem_op, w_misalign, w_access;
  logic            w_req, w_stall, w_done, w_wb_load;
  logic [1:0]      w_off;
  logic [BEW-1:0]  w_be;
  logic [XLEN-1:0] w_wdata, w_ldata;

  logic [XLEN-1:0] r_alu_res, r_mem_dout;
  logic [1:0]      r_wb_sel;
  logic            r_vld, r_misalign;
  logic [RDW-1:0]  r_rd;

  assign w_mem_op = EX_MEM_vld & (EX_MEM_mem_read | EX_MEM_mem_write);

`ifdef MEM_MISALIGN_CHK_EN
  assign w_misalign = w_mem_op &
                      (((EX_MEM_funct3[1:0] == 2'b01) & EX_MEM_alu_res[0]) |
                       ((EX_MEM_funct3[1:0] == 2'b10) & (EX_MEM_alu_res[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access = w_mem_op & ~w_misalign;
  assign w_off    = eff_off(EX_MEM_funct3, EX_MEM_alu_res[1:0]);

  mem_align u_align (
    .i_funct3 (EX_MEM_funct3),
    .i_off    (w_off),
    .i_rs2    (EX_MEM_rs2_data),
    .i_rdata  (dmem.dmem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_ldata  (w_ldata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state, request and stall; w_done marks a memory op completing this cycle.
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_req = 1'b1;
          if (dmem.dmem_gnt && EX_MEM_mem_write) begin
            w_done = 1'b1;
          end else if (dmem.dmem_gnt) begin
            w_next  = ST_RESP;
            w_stall = 1'b1;
          end else begin
            w_next  = ST_REQ;
            w_stall = 1'b1;
          end
        end
      end
      ST_REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmem.dmem_gnt) begin
          if (EX_MEM_mem_write) begin
            w_done  = 1'b1;
            w_stall = 1'b0;
            w_next  = ST_IDLE;
          end else begin
            w_next  = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        w_stall = 1'b1;
        if (dmem.dmem_rvalid) begin
          w_done  = 1'b1;
          w_stall = 1'b0;
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request side is quiet during reset so the bus reads idle.
  assign dmem.dmem_req   = w_req & ~rst;
  assign dmem.dmem_we    = w_req & ~rst & EX_MEM_mem_write;
  assign dmem.dmem_addr  = {EX_MEM_alu_res[XLEN-1:2], 2'b00};
  assign dmem.dmem_be    = (w_req & ~rst) ? w_be : '0;
  assign dmem.dmem_wdata = w_wdata;
  assign MEM_stall       = w_stall & ~rst;

  // Non-memory and trapped ops retire from IDLE at once; memory ops retire on w_done.
  assign w_wb_load = ((r_state == ST_IDLE) & EX_MEM_vld & (~w_mem_op | w_misalign)) | w_done;

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= 1'b0;
      r_alu_res  <= '0;
      r_mem_dout <= '0;
      r_wb_sel   <= '0;
      r_rd       <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_vld <= w_wb_load;
      if (w_wb_load) begin
        r_alu_res  <= EX_MEM_alu_res;
        r_mem_dout <= (w_done & EX_MEM_mem_read) ? w_ldata : '0;
        r_wb_sel   <= EX_MEM_wb_sel;
        r_rd       <= EX_MEM_rd;
        r_misalign <= w_misalign;
      end
    end
  end

  assign MEM_WB_vld      = r_vld;
  assign MEM_WB_alu_res  = r_alu_res;
  assign MEM_WB_mem_dout = r_mem_dout;
  assign MEM_WB_wb_sel   = r_wb_sel;
  assign MEM_WB_rd       = r_rd;
  assign MEM_WB_misalign = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change 1 time unit after each rising edge; combinational outputs are
// checked 1 unit later, registered outputs 1 unit after the following edge.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_vld, ex_rd_en, ex_wr_en;
  logic [31:0] ex_alu, ex_rs2;
  logic [2:0]  ex_f3;
  logic [1:0]  ex_wb;
  logic [4:0]  ex_rd;
  logic        stall, wb_vld, wb_mis;
  logic [31:0] wb_alu, wb_dout;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_if dif ();

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .EX_MEM_vld       (ex_vld),
    .EX_MEM_alu_res   (ex_alu),
    .EX_MEM_rs2_data  (ex_rs2),
    .EX_MEM_funct3    (ex_f3),
    .EX_MEM_mem_read  (ex_rd_en),
    .EX_MEM_mem_write (ex_wr_en),
    .EX_MEM_wb_sel    (ex_wb),
    .EX_MEM_rd        (ex_rd),
    .dmem             (dif.master),
    .MEM_stall        (stall),
    .MEM_WB_alu_res   (wb_alu),
    .MEM_WB_mem_dout  (wb_dout),
    .MEM_WB_wb_sel    (wb_sel),
    .MEM_WB_vld       (wb_vld),
    .MEM_WB_rd        (wb_rd),
    .MEM_WB_misalign  (wb_mis)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    ex_vld = 0; ex_rd_en = 0; ex_wr_en = 0; ex_alu = '0; ex_rs2 = '0;
    ex_f3 = '0; ex_wb = '0; ex_rd = '0;
    dif.dmem_gnt = 0; dif.dmem_rvalid = 0; dif.dmem_rdata = '0;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [1:0] wb, input logic [4:0] rd);
    ex_vld = 1; ex_rd_en = rd_en; ex_wr_en = wr_en; ex_f3 = f3;
    ex_alu = alu; ex_rs2 = rs2; ex_wb = wb; ex_rd = rd;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    tick(); tick();
    n_tests++; if (wb_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", wb_vld); end
    n_tests++; if (wb_alu !== 32'h0) begin n_fail++; $display("FAIL reset_alu got %h want 0", wb_alu); end
    n_tests++; if (wb_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0", wb_dout); end
    n_tests++; if ({wb_sel, wb_rd, wb_mis} !== 8'h0) begin n_fail++; $display("FAIL reset_fields got %h want 0", {wb_sel, wb_rd, wb_mis}); end
    n_tests++; if ({dif.dmem_req, dif.dmem_we, dif.dmem_be, stall} !== 7'h0) begin n_fail++; $display("FAIL reset_bus got %h want 0", {dif.dmem_req, dif.dmem_we, dif.dmem_be, stall}); end
    rst = 0;
    tick();
  endtask

  task automatic test_nonmem();
    drive_op(0, 0, 3'b000, 32'h1234, 32'h0, WB_ALU, 5'd5);
    settle();
    n_tests++; if ({stall, dif.dmem_req} !== 2'b00) begin n_fail++; $display("FAIL add_stall_req got %b want 00", {stall, dif.dmem_req}); end
    tick();
    n_tests++; if (wb_vld !== 1'b1) begin n_fail++; $display("FAIL add_vld got %b want 1", wb_vld); end
    n_tests++; if (wb_alu !== 32'h1234) begin n_fail++; $display("FAIL add_alu got %h want 1234", wb_alu); end
    n_tests++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL add_rd got %0d want 5", wb_rd); end
    n_tests++; if (wb_dout !== 32'h0) begin n_fail++; $display("FAIL add_dout got %h want 0", wb_dout); end
    drive_idle();
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    drive_op(0, 1, f3, alu, rs2, WB_ALU, 5'd0);
    dif.dmem_gnt = 1;
    settle();
    n_tests++; if ({dif.dmem_req, dif.dmem_we} !== 2'b11) begin n_fail++; $display("FAIL st_req_we got %b want 11", {dif.dmem_req, dif.dmem_we}); end
    n_tests++; if (dif.dmem_addr !== exp_addr) begin n_fail++; $display("FAIL st_addr got %h want %h", dif.dmem_addr, exp_addr); end
    n_tests++; if (dif.dmem_be !== exp_be) begin n_fail++; $display("FAIL st_be got %b want %b", dif.dmem_be, exp_be); end
    n_tests++; if (dif.dmem_wdata !== exp_wdata) begin n_fail++; $display("FAIL st_wdata got %h want %h", dif.dmem_wdata, exp_wdata); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_stall got %b want 0", stall); end
    tick();
    n_tests++; if ({wb_vld, wb_dout} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL st_wb got %b/%h want 1/0", wb_vld, wb_dout); end
    drive_idle();
  endtask

  // gnt in cycle 0, rvalid in cycle 3.
  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_dout);
    drive_op(1, 0, f3, 32'h2001, 32'h0, WB_MEM, 5'd7);
    dif.dmem_gnt = 1;
    settle();
    n_tests++; if ({dif.dmem_req, dif.dmem_we, stall} !== 3'b101) begin n_fail++; $display("FAIL lb_c0 got %b want 101", {dif.dmem_req, dif.dmem_we, stall}); end
    tick();
    dif.dmem_gnt = 0;
    for (int c = 1; c <= 2; c++) begin
      n_tests++; if (wb_vld !== 1'b0) begin n_fail++; $display("FAIL lb_bubble c%0d got %b want 0", c, wb_vld); end
      settle();
      n_tests++; if ({dif.dmem_req, stall} !== 2'b01) begin n_fail++; $display("FAIL lb_resp c%0d got %b want 01", c, {dif.dmem_req, stall}); end
      tick();
    end
    dif.dmem_rvalid = 1; dif.dmem_rdata = 32'h0000_8000;
    settle();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lb_c3_stall got %b want 0", stall); end
    tick();
    n_tests++; if ({wb_vld, wb_rd, wb_sel} !== {1'b1, 5'd7, WB_MEM}) begin n_fail++; $display("FAIL lb_wb got %b/%0d/%b want 1/7/01", wb_vld, wb_rd, wb_sel); end
    n_tests++; if (wb_dout !== exp_dout) begin n_fail++; $display("FAIL lb_dout f3=%b got %h want %h", f3, wb_dout, exp_dout); end
    drive_idle();
  endtask

  task automatic test_lw_wait();
    drive_op(1, 0, F3_W, 32'h4008, 32'h0, WB_MEM, 5'd9);
    for (int c = 0; c < 2; c++) begin
      settle();
      n_tests++; if ({dif.dmem_req, stall} !== 2'b11) begin n_fail++; $display("FAIL lw_wait c%0d got %b want 11", c, {dif.dmem_req, stall}); end
      n_tests++; if (dif.dmem_addr !== 32'h4008) begin n_fail++; $display("FAIL lw_addr c%0d got %h want 4008", c, dif.dmem_addr); end
      tick();
      n_tests++; if (wb_vld !== 1'b0) begin n_fail++; $display("FAIL lw_bubble c%0d got %b want 0", c, wb_vld); end
    end
    dif.dmem_gnt = 1;
    settle();
    n_tests++; if ({dif.dmem_req, stall, dif.dmem_be} !== 6'b11_1111) begin n_fail++; $display("FAIL lw_gnt got %b want 111111", {dif.dmem_req, stall, dif.dmem_be}); end
    tick();
    dif.dmem_gnt = 0; dif.dmem_rvalid = 1; dif.dmem_rdata = 32'h1122_3344;
    tick();
    n_tests++; if ({wb_vld, wb_dout} !== {1'b1, 32'h1122_3344}) begin n_fail++; $display("FAIL lw_done got %b/%h want 1/11223344", wb_vld, wb_dout); end
    drive_idle();
  endtask

  task automatic test_reset_in_resp();
    drive_op(1, 0, F3_W, 32'h5000, 32'h0, WB_MEM, 5'd3);
    dif.dmem_gnt = 1;
    tick();
    dif.dmem_gnt = 0;
    rst = 1; ex_vld = 0;
    tick();
    rst = 0; drive_idle();
    dif.dmem_rvalid = 1; dif.dmem_rdata = 32'hDEAD_BEEF;
    settle();
    n_tests++; if ({dif.dmem_req, stall} !== 2'b00) begin n_fail++; $display("FAIL rr_bus got %b want 00", {dif.dmem_req, stall}); end
    n_tests++; if ({wb_vld, wb_dout} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rr_wb_rst got %b/%h want 0/0", wb_vld, wb_dout); end
    tick();
    n_tests++; if ({wb_vld, wb_dout} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rr_late_rvalid got %b/%h want 0/0", wb_vld, wb_dout); end
    dif.dmem_rvalid = 0;
    drive_op(0, 0, 3'b000, 32'h77, 32'h0, WB_PC4, 5'd4);
    tick();
    n_tests++; if ({wb_vld, wb_alu, wb_sel} !== {1'b1, 32'h77, WB_PC4}) begin n_fail++; $display("FAIL rr_idle_op got %b/%h/%b want 1/77/10", wb_vld, wb_alu, wb_sel); end
    drive_idle();
  endtask

  task automatic test_misalign();
    drive_op(1, 0, F3_H, 32'h3001, 32'h0, WB_MEM, 5'd2);
`ifdef MEM_MISALIGN_CHK_EN
    settle();
    n_tests++; if ({dif.dmem_req, stall} !== 2'b00) begin n_fail++; $display("FAIL mis_bus got %b want 00", {dif.dmem_req, stall}); end
    tick();
    n_tests++; if ({wb_vld, wb_mis, wb_dout} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL mis_wb got %b/%b/%h want 1/1/0", wb_vld, wb_mis, wb_dout); end
`else
    dif.dmem_gnt = 1;
    settle();
    n_tests++; if ({dif.dmem_req, dif.dmem_addr, dif.dmem_be} !== {1'b1, 32'h3000, 4'b0011}) begin n_fail++; $display("FAIL mis_bus got %b/%h/%b want 1/3000/0011", dif.dmem_req, dif.dmem_addr, dif.dmem_be); end
    tick();
    dif.dmem_gnt = 0; dif.dmem_rvalid = 1; dif.dmem_rdata = 32'h7F00_8001;
    tick();
    n_tests++; if ({wb_vld, wb_mis, wb_dout} !== {2'b10, 32'hFFFF_8001}) begin n_fail++; $display("FAIL mis_wb got %b/%b/%h want 1/0/ffff8001", wb_vld, wb_mis, wb_dout); end
`endif
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store(F3_B, 32'h1003, 32'h0000_00AB, 32'h1000, 4'b1000, 32'hABAB_ABAB);
    test_store(F3_H, 32'h1002, 32'h1234_CDEF, 32'h1000, 4'b1100, 32'hCDEF_CDEF);
    test_store(F3_W, 32'h1004, 32'h1234_5678, 32'h1004, 4'b1111, 32'h1234_5678);
    test_load_byte(F3_B,  32'hFFFF_FF80);
    test_load_byte(F3_BU, 32'h0000_0080);
    test_lw_wait();
    test_reset_in_resp();
    test_misalign();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
